struct_member_capture_fifo: RTL and testbench
=============================================

Name: struct_member_capture_fifo

Overview:
- Downstream consumer of the 8-bit unpacked-struct-member output (`data` field) of the struct test top.
- Each accepted sample is captured into a record {data, seq, par} and buffered in a small FIFO with a valid/ready output.
- The emulation bench uses the record to check that the struct-member bits arrive intact, in order, and without loss.

Parameters:
- DATA_W, 8: width of the captured struct member.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- SEQ_W, 4: width of the per-record sequence number.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_a  input  DATA_W  struct member data from upstream.
- i_valid  input  1  upstream sample strobe.
- o_ready  output  1  capture possible (FIFO not full).
- o_data  output  DATA_W  head record data field.
- o_seq  output  SEQ_W  head record sequence number.
- o_par  output  1  head record even parity (XOR of all data bits).
- o_valid  output  1  head record present.
- i_ready  input  1  downstream accepts head record.
- o_count  output  clog2(DEPTH)+1  occupancy, 0..DEPTH.
- o_ovf  output  1  sticky overflow flag.

Behaviour:
- Clock and reset: one clock (i_clk). Reset i_rst is asynchronous, active-high.
- Reset values:
  - Pointers, o_count, o_valid, o_ovf, and the sequence counter are 0.
  - o_ready=1.
  - Storage contents are don't-care, but o_data/o_seq/o_par read 0 while empty.
- Push:
  - Occurs when i_valid=1 and not full.
  - Writes {i_a, seq_ctr, ^i_a} at the write pointer.
  - The write pointer advances modulo DEPTH.
  - seq_ctr increments modulo 2^SEQ_W, wrapping 15→0 at SEQ_W=4.
- Pop:
  - Occurs when o_valid=1 and i_ready=1; the read pointer advances modulo DEPTH.
  - i_ready while empty is ignored.
- Output timing:
  - Outputs are first-word-fall-through from registered storage.
  - A push in cycle N makes o_valid=1 with that record on o_data/o_seq/o_par in cycle N+1. No combinational path from i_a to outputs.
- Stall: while o_valid=1 and i_ready=0, o_data/o_seq/o_par remain stable.
- o_ready: equals !full, registered-state derived only. No combinational dependence on i_ready.
- Full with pop in the same cycle:
  - Push is still refused, because o_ready was 0.
  - The sample is dropped and treated as overflow.
- Overflow:
  - i_valid=1 while full sets o_ovf=1.
  - The sample is discarded; seq_ctr does not increment.
  - o_ovf clears only on reset.
- Simultaneous push and pop when neither empty nor full: o_count is unchanged and both pointers advance.
- Push into empty with i_ready=1 in the same cycle:
  - The pop is ignored, because o_valid=0 that cycle.
  - The record appears next cycle.
- o_count arithmetic: +1 on push only, −1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never goes below 0.
- Reset mid-operation: on i_rst assertion, all buffered records are discarded immediately, regardless of the clock. Outputs return to reset values within the same cycle.
- Pointer wrap: pointers are clog2(DEPTH) bits wide with an extra wrap bit for full/empty distinction. full = pointers equal and wrap bits differ.

Test Plan:
- Tie-high stream:
  - Stimulus: i_a=8'hFF, i_valid=1 for 4 cycles, i_ready=0.
  - Response: records seq 0..3, o_par=0; o_count=4, o_ready=0, o_ovf=0.
  - Fifth cycle with i_valid=1: o_ovf=1, o_count stays 4.
- Drain order:
  - Stimulus: from the full state above, i_ready=1 for 4 cycles.
  - Response: o_seq reads 0,1,2,3 with o_data=FF. Then o_valid=0, o_count=0, o_ready=1.
- Parity and latency:
  - Stimulus: push 8'h01 in cycle N.
  - Response: cycle N+1 shows o_valid=1, o_data=01, o_par=1. Push 8'h03 gives o_par=0.
- Sequence wrap:
  - Stimulus: 20 pushes with i_ready=1 continuous.
  - Response: o_seq runs 0..15,0..3. No overflow. o_count ≤1 throughout.
- Full plus pop:
  - Stimulus: with the FIFO full, assert i_valid=1 and i_ready=1 in the same cycle.
  - Response: one pop, push refused, o_ovf=1, o_count=3.
- Async reset:
  - Stimulus: with 2 records buffered, assert i_rst between clock edges.
  - Response: o_valid=0, o_count=0, o_ovf=0, o_ready=1 before the next edge. The first push after release gets o_seq=0.

Source files
------------

// File: rtl/struct_member_capture_fifo.sv
// Captures upstream struct-member samples as {data, seq, par} records into a FWFT FIFO; a push is visible on the outputs one cycle later.
// o_ready is !full from registered state only; a sample offered while full is dropped and latches the sticky o_ovf.
module struct_member_capture_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int SEQ_W  = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [DATA_W-1:0]        i_a,
   input  logic                     i_valid,
   output logic                     o_ready,
   output logic [DATA_W-1:0]        o_data,
   output logic [SEQ_W-1:0]         o_seq,
   output logic                     o_par,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_ovf
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SEQ_W-1:0]  seq;
      logic              par;
   } rec_t;

   rec_t              mem_q [DEPTH];
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic              ovf_q, ovf_d;
   logic              full, empty, push, pop;
   rec_t              rec_in, head;

   // The extra MSB on each pointer tells full (wrap bits differ) from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push  = i_valid && !full;
   assign pop   = !empty && i_ready;

   always_comb begin
      rec_in.data = i_a;
      rec_in.seq  = seq_q;
      rec_in.par  = ^i_a;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      seq_d    = seq_q;
      ovf_d    = ovf_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         seq_d    = seq_q + SEQ_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
      if (i_valid && full) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         seq_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         seq_q    <= seq_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= rec_in;
      end
   end

   // Stale storage is masked so the head fields read zero whenever empty.
   assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign o_data  = head.data;
   assign o_seq   = head.seq;
   assign o_par   = head.par;
   assign o_valid = !empty;
   assign o_ready = !full;
   assign o_count = wr_ptr_q - rd_ptr_q;
   assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_struct_member_capture_fifo.sv
// Scoreboard bench for struct_member_capture_fifo: inputs driven 1 time unit after the rising edge, outputs sampled between edges.
module tb_struct_member_capture_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int SEQ_W  = 4;

   logic              i_clk;
   logic              i_rst;
   logic [DATA_W-1:0] i_a;
   logic              i_valid;
   logic              o_ready;
   logic [DATA_W-1:0] o_data;
   logic [SEQ_W-1:0]  o_seq;
   logic              o_par;
   logic              o_valid;
   logic              i_ready;
   logic [2:0]        o_count;
   logic              o_ovf;

   int checks   = 0;
   int failures = 0;

   logic [DATA_W+SEQ_W:0] sb[$];
   logic [SEQ_W-1:0]      m_seq;
   logic                  m_ovf;

   struct_member_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_a     (i_a),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_seq   (o_seq),
      .o_par   (o_par),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_count (o_count),
      .o_ovf   (o_ovf)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #90000;
      $display("FAIL watchdog time limit expired");
      $fatal(1);
   end

   // One clock cycle: compare popped head against the scoreboard, update the model, advance.
   task automatic step(input logic [DATA_W-1:0] a, input logic v, input logic r);
      logic [DATA_W+SEQ_W:0] exp;
      bit full_pre;
      i_a = a; i_valid = v; i_ready = r;
      @(negedge i_clk);
      full_pre = (sb.size() >= DEPTH);
      checks++;
      if (o_valid !== (sb.size() != 0)) begin
         failures++;
         $display("FAIL sb_valid got=%b exp=%b", o_valid, (sb.size() != 0));
      end
      if (sb.size() != 0 && r) begin
         exp = sb.pop_front();
         checks++;
         if ({o_data, o_seq, o_par} !== exp) begin
            failures++;
            $display("FAIL sb_record got=%h/%h/%b exp=%h/%h/%b", o_data, o_seq, o_par,
                     exp[DATA_W+SEQ_W:SEQ_W+1], exp[SEQ_W:1], exp[0]);
         end
      end
      if (v && !full_pre) begin
         sb.push_back({a, m_seq, ^a});
         m_seq = m_seq + 1'b1;
      end
      if (v && full_pre) m_ovf = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0; i_ready = 1'b0;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      #2;
      i_rst = 1'b0;
      sb.delete();
      m_seq = '0;
      m_ovf = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_valid = 1'b0; i_ready = 1'b0; i_a = '0;
      i_rst = 1'b1;
      #2;
      checks++;
      if ({o_valid, o_count, o_ready, o_ovf, o_data, o_seq, o_par} !== {1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got v=%b c=%0d r=%b ovf=%b d=%h s=%h p=%b", o_valid, o_count, o_ready, o_ovf, o_data, o_seq, o_par);
      end
      i_rst = 1'b0;
      sb.delete(); m_seq = '0; m_ovf = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_tie_high();
      for (int i = 0; i < 4; i++) begin
         step(8'hFF, 1'b1, 1'b0);
         checks++;
         if (o_count !== 3'(i + 1) || o_seq !== 4'h0 || o_par !== 1'b0) begin
            failures++;
            $display("FAIL tie_high_fill%0d got c=%0d s=%h p=%b exp c=%0d s=0 p=0", i, o_count, o_seq, o_par, i + 1);
         end
      end
      checks++;
      if (o_count !== 3'd4 || o_ready !== 1'b0 || o_ovf !== 1'b0) begin
         failures++;
         $display("FAIL tie_high_full got c=%0d r=%b ovf=%b exp c=4 r=0 ovf=0", o_count, o_ready, o_ovf);
      end
      step(8'hFF, 1'b1, 1'b0);
      checks++;
      if (o_ovf !== 1'b1 || o_count !== 3'd4) begin
         failures++;
         $display("FAIL tie_high_ovf got ovf=%b c=%0d exp ovf=1 c=4", o_ovf, o_count);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (o_seq !== 4'(i) || o_data !== 8'hFF) begin
            failures++;
            $display("FAIL drain_order%0d got s=%h d=%h exp s=%h d=ff", i, o_seq, o_data, i);
         end
         step(8'h00, 1'b0, 1'b1);
      end
      checks++;
      if (o_valid !== 1'b0 || o_count !== 3'd0 || o_ready !== 1'b1) begin
         failures++;
         $display("FAIL drain_empty got v=%b c=%0d r=%b exp v=0 c=0 r=1", o_valid, o_count, o_ready);
      end
   endtask

   task automatic test_parity_latency();
      step(8'h01, 1'b1, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h01 || o_par !== 1'b1) begin
         failures++;
         $display("FAIL parity_01 got v=%b d=%h p=%b exp v=1 d=01 p=1", o_valid, o_data, o_par);
      end
      step(8'h03, 1'b1, 1'b1);
      checks++;
      if (o_data !== 8'h03 || o_par !== 1'b0 || o_count !== 3'd1) begin
         failures++;
         $display("FAIL parity_03 got d=%h p=%b c=%0d exp d=03 p=0 c=1", o_data, o_par, o_count);
      end
      step(8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_empty_push_pop();
      step(8'hA5, 1'b1, 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'hA5 || o_count !== 3'd1) begin
         failures++;
         $display("FAIL empty_push_pop got v=%b d=%h c=%0d exp v=1 d=a5 c=1", o_valid, o_data, o_count);
      end
      step(8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_seq_wrap();
      do_reset();
      for (int k = 0; k < 20; k++) begin
         step(8'($urandom), 1'b1, 1'b1);
         checks++;
         if (o_seq !== 4'(k % 16) || o_count > 3'd1 || o_ovf !== 1'b0) begin
            failures++;
            $display("FAIL seq_wrap%0d got s=%h c=%0d ovf=%b exp s=%h c<=1 ovf=0", k, o_seq, o_count, o_ovf, k % 16);
         end
      end
      step(8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < 4; i++) step(8'(8'h10 + i), 1'b1, 1'b0);
      step(8'h55, 1'b1, 1'b1);
      checks++;
      if (o_ovf !== 1'b1 || o_count !== 3'd3 || o_ready !== 1'b1) begin
         failures++;
         $display("FAIL full_pop got ovf=%b c=%0d r=%b exp ovf=1 c=3 r=1", o_ovf, o_count, o_ready);
      end
      for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 60; i++) begin
         step(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         checks++;
         if (o_count !== 3'(sb.size()) || o_ovf !== m_ovf) begin
            failures++;
            $display("FAIL b2b_count%0d got c=%0d ovf=%b exp c=%0d ovf=%b", i, o_count, o_ovf, sb.size(), m_ovf);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(8'h11, 1'b1, 1'b0);
      step(8'h22, 1'b1, 1'b0);
      #2;
      i_rst = 1'b1;
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_count !== 3'd0 || o_ovf !== 1'b0 || o_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset got v=%b c=%0d ovf=%b r=%b exp v=0 c=0 ovf=0 r=1", o_valid, o_count, o_ovf, o_ready);
      end
      #2;
      i_rst = 1'b0;
      sb.delete(); m_seq = '0; m_ovf = 1'b0;
      @(posedge i_clk);
      #1;
      step(8'h33, 1'b1, 1'b0);
      checks++;
      if (o_seq !== 4'h0 || o_data !== 8'h33) begin
         failures++;
         $display("FAIL async_first_seq got s=%h d=%h exp s=0 d=33", o_seq, o_data);
      end
   endtask

   initial begin
      i_rst = 1'b0; i_a = '0; i_valid = 1'b0; i_ready = 1'b0;
      m_seq = '0; m_ovf = 1'b0;
      test_reset();
      test_tie_high();
      test_drain();
      test_parity_latency();
      test_empty_push_pop();
      test_seq_wrap();
      test_full_pop();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
